// File: rtl/alu_core.sv
// alu_core: 32-bit integer ALU with Z/N/C/V flags, one registered stage (1-cycle latency).
// Optional build macro ALU_MUL_EN turns opcode 11 into MUL (low 32 bits of the unsigned product).
module alu_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  alu_op,
  output logic        valid_out,
  output logic [31:0] Y,
  output logic [3:0]  FLAGS
);

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd11;
`endif

  // Flag word layout: {V, C, N, Z}; Z and N always come from the final result.
  function automatic logic [3:0] pack_flags(input logic [DATA_W-1:0] y,
                                            input logic c, input logic v);
    pack_flags = {v, c, y[DATA_W-1], ~|y};
  endfunction

  logic signed [DATA_W-1:0] a_s_p0;
  logic signed [DATA_W-1:0] b_s_p0;
  logic        [DATA_W-1:0] b_op_p0;
  logic                     cin_p0;
  logic        [DATA_W:0]   sum_p0;
  logic        [4:0]        shamt_p0;
  logic        [DATA_W-1:0] y_p0;
  logic                     c_p0;
  logic                     v_p0;
  logic        [3:0]        flags_p0;

  logic        [DATA_W-1:0] y_p1;
  logic        [3:0]        flags_p1;
  logic                     vld_p1;

  // ---- stage p0: combinational core ----
  assign a_s_p0   = A;
  assign b_s_p0   = B;
  assign shamt_p0 = B[4:0];

  // SUB reuses the adder as A + ~B + 1 so the carry out means "no borrow".
  always_comb begin
    b_op_p0 = B;
    cin_p0  = 1'b0;
    if (alu_op == OP_SUB) begin
      b_op_p0 = ~B;
      cin_p0  = 1'b1;
    end
    sum_p0 = {1'b0, A} + {1'b0, b_op_p0} + {{DATA_W{1'b0}}, cin_p0};
  end

  always_comb begin
    y_p0 = '0;
    c_p0 = 1'b0;
    v_p0 = 1'b0;
    case (alu_op)
      OP_ADD, OP_SUB: begin
        y_p0 = sum_p0[DATA_W-1:0];
        c_p0 = sum_p0[DATA_W];
        v_p0 = (A[DATA_W-1] == b_op_p0[DATA_W-1]) &&
               (sum_p0[DATA_W-1] != A[DATA_W-1]);
      end
      OP_AND:  y_p0 = A & B;
      OP_OR:   y_p0 = A | B;
      OP_XOR:  y_p0 = A ^ B;
      OP_NOT:  y_p0 = ~(A | B);
      OP_SLL:  y_p0 = A << shamt_p0;
      OP_SRL:  y_p0 = A >> shamt_p0;
      OP_SRA:  y_p0 = a_s_p0 >>> shamt_p0;
      OP_SLT:  y_p0 = {{(DATA_W-1){1'b0}}, (a_s_p0 < b_s_p0)};
      OP_SLTU: y_p0 = {{(DATA_W-1){1'b0}}, (A < B)};
`ifdef ALU_MUL_EN
      OP_MUL:  y_p0 = A * B;
`endif
      default: y_p0 = '0;
    endcase
    flags_p0 = pack_flags(y_p0, c_p0, v_p0);
  end

  // ---- stage p1: result register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      y_p1     <= '0;
      flags_p1 <= '0;
    end else if (valid_in) begin
      vld_p1   <= 1'b1;
      y_p1     <= y_p0;
      flags_p1 <= flags_p0;
    end else begin
      vld_p1   <= 1'b0;
    end
  end

  assign valid_out = vld_p1;
  assign Y         = y_p1;
  assign FLAGS     = flags_p1;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed vectors, reset/hold behaviour and random ops vs. a reference model.
module tb_alu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  alu_op;
  logic        valid_out;
  logic [31:0] Y;
  logic [3:0]  FLAGS;

  int n_chk  = 0;
  int n_fail = 0;

  alu_core dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .A        (A),
    .B        (B),
    .alu_op   (alu_op),
    .valid_out(valid_out),
    .Y        (Y),
    .FLAGS    (FLAGS)
  );

  always #5 clk = ~clk;

  // Reference model from plain arithmetic: returns {V,C,N,Z, Y}.
  function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0]     y;
    logic            c;
    logic            v;
    longint          sa;
    longint          sb;
    longint          sr;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned ur;
    y  = 32'd0;
    c  = 1'b0;
    v  = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sr = 0;
    ur = 0;
    case (op)
      4'd0: begin
        ur = ua + ub;
        y  = ur[31:0];
        c  = (ur >> 32) != 0;
        sr = sa + sb;
        v  = (sr != longint'($signed(y)));
      end
      4'd1: begin
        y  = a - b;
        c  = (a >= b);
        sr = sa - sb;
        v  = (sr != longint'($signed(y)));
      end
      4'd2:  y = a & b;
      4'd3:  y = a | b;
      4'd4:  y = a ^ b;
      4'd5:  y = ~(a | b);
      4'd6:  y = a << b[4:0];
      4'd7:  y = a >> b[4:0];
      4'd8: begin
        sr = sa >>> b[4:0];
        y  = sr[31:0];
      end
      4'd9:  y = (sa < sb) ? 32'd1 : 32'd0;
      4'd10: y = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      4'd11: begin
        ur = ua * ub;
        y  = ur[31:0];
      end
`endif
      default: y = 32'd0;
    endcase
    return {v, c, y[31], (y == 32'd0), y};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one op with valid_in=1 and check the registered result one edge later.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ey, input logic [3:0] ef);
    @(negedge clk);
    valid_in = 1'b1;
    alu_op   = op;
    A        = a;
    B        = b;
    @(posedge clk);
    #1;
    chk({tag, ".Y"}, Y, ey);
    chk({tag, ".FLAGS"}, {28'd0, FLAGS}, {28'd0, ef});
    chk({tag, ".vld"}, {31'd0, valid_out}, 32'd1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [35:0] exp;
    logic [31:0] held_y;
    logic [3:0]  held_f;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    rst      = 1'b1;
    valid_in = 1'b1;
    alu_op   = 4'd0;
    A        = 32'd5;
    B        = 32'd7;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.Y", Y, 32'd0);
    chk("reset.FLAGS", {28'd0, FLAGS}, 32'd0);
    chk("reset.vld", {31'd0, valid_out}, 32'd0);

    @(negedge clk);
    rst = 1'b0;

    run_op("add_1_2",   4'd0,  32'd1,          32'd2,          32'd3,          4'b0000);
    run_op("sub_3_4",   4'd1,  32'd3,          32'd4,          32'hFFFF_FFFF,  4'b0010);
    run_op("sub_ovf",   4'd1,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  4'b1100);
    run_op("add_carry", 4'd0,  32'hFFFF_FFFF,  32'd1,          32'd0,          4'b0101);
    run_op("and",       4'd2,  32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00,  4'b0000);
    run_op("or",        4'd3,  32'hFF00_FF00,  32'h0F0F_0F0F,  32'hFF0F_FF0F,  4'b0010);
    run_op("xor",       4'd4,  32'hFF00_FF00,  32'h0F0F_0F0F,  32'hF00F_F00F,  4'b0010);
    run_op("not",       4'd5,  32'hFF00_FF00,  32'h0F0F_0F0F,  32'h00F0_00F0,  4'b0000);
    run_op("sll",       4'd6,  32'd1,          32'd4,          32'h0000_0010,  4'b0000);
    run_op("srl",       4'd7,  32'd1,          32'd4,          32'd0,          4'b0001);
    run_op("sra",       4'd8,  32'h8000_0000,  32'd1,          32'hC000_0000,  4'b0010);
    run_op("sll_hiB",   4'd6,  32'd1,          32'hFFFF_FFE3,  32'd8,          4'b0000);
    run_op("slt",       4'd9,  32'hFFFF_FFFF,  32'd1,          32'd1,          4'b0000);
    run_op("sltu",      4'd10, 32'hFFFF_FFFF,  32'd1,          32'd0,          4'b0001);
    run_op("rsv12",     4'd12, 32'h1234_5678,  32'h9ABC_DEF0,  32'd0,          4'b0001);
`ifdef ALU_MUL_EN
    run_op("mul",       4'd11, 32'h0001_0003,  32'h0001_0005,  32'h0008_000F,  4'b0000);
`else
    run_op("rsv11",     4'd11, 32'h0001_0003,  32'h0001_0005,  32'd0,          4'b0001);
`endif

    // valid_in low: outputs hold, valid_out drops
    run_op("pre_hold", 4'd0, 32'd40, 32'd2, 32'd42, 4'b0000);
    @(negedge clk);
    valid_in = 1'b0;
    alu_op   = 4'd1;
    A        = 32'd0;
    B        = 32'd9;
    @(posedge clk);
    #1;
    chk("hold.Y", Y, 32'd42);
    chk("hold.FLAGS", {28'd0, FLAGS}, 32'd0);
    chk("hold.vld", {31'd0, valid_out}, 32'd0);

    // reset mid-stream takes priority over valid_in
    run_op("pre_rst", 4'd1, 32'd3, 32'd4, 32'hFFFF_FFFF, 4'b0010);
    @(negedge clk);
    rst      = 1'b1;
    valid_in = 1'b1;
    alu_op   = 4'd3;
    A        = 32'hFFFF_0000;
    B        = 32'h0000_FFFF;
    @(posedge clk);
    #1;
    chk("midrst.Y", Y, 32'd0);
    chk("midrst.FLAGS", {28'd0, FLAGS}, 32'd0);
    chk("midrst.vld", {31'd0, valid_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 4'd3, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_FFFF, 4'b0010);

    // random back-to-back ops with occasional idle cycles
    for (int i = 0; i < 400; i++) begin
      op  = 4'($urandom_range(0, 15));
      a   = pick_operand();
      b   = pick_operand();
      exp = ref_alu(op, a, b);
      if ($urandom_range(0, 7) == 0) begin
        held_y = Y;
        held_f = FLAGS;
        @(negedge clk);
        valid_in = 1'b0;
        A        = a;
        B        = b;
        alu_op   = op;
        @(posedge clk);
        #1;
        chk("rnd_idle.Y", Y, held_y);
        chk("rnd_idle.FLAGS", {28'd0, FLAGS}, {28'd0, held_f});
        chk("rnd_idle.vld", {31'd0, valid_out}, 32'd0);
      end
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, exp[31:0], exp[35:32]);
    end

    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    chk("final_idle.vld", {31'd0, valid_out}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
